// File: rtl/lsu_dmem_master.sv
// Load/store initiator for the data-memory port.
// Takes one request at a time from execute and places it on the 8-byte memory word
// with the right byte lanes. It waits a bounded time for mem_ack, then returns the
// extended load data, or an error code, on a valid/ready response channel.
module lsu_dmem_master #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        data_r_en,
    output logic        data_w_en,
    output logic [7:0]  data_wmask,
    output logic [63:0] data_addr,
    output logic [63:0] data_w,
    input  logic [63:0] data_r,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [8:0] MAX_WAIT_W = 9'(MAX_WAIT);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MISALGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Error code for a new request. funct3=111 takes priority over alignment,
    // and alignment takes priority over the load-only funct3 codes used on a store.
    function automatic logic [1:0] req_check(input logic [2:0] f3, input logic we,
                                             input logic [2:0] off);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            2'b10:   mis = (off[1:0] != 2'b00);
            2'b11:   mis = (off != 3'b000);
            default: mis = 1'b0;
        endcase
        if (f3 == 3'b111) begin
            req_check = ERR_ILLEGAL;
        end else if (mis) begin
            req_check = ERR_MISALGN;
        end else if (we && f3[2]) begin
            req_check = ERR_ILLEGAL;
        end else begin
            req_check = ERR_OK;
        end
    endfunction

    // Byte mask for the access width before it is shifted into its lane.
    function automatic logic [7:0] base_mask(input logic [1:0] size);
        case (size)
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            2'b11:   base_mask = 8'hFF;
            default: base_mask = 8'h00;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it to 64 bits.
    function automatic logic [63:0] load_ext(input logic [63:0] word, input logic [2:0] f3,
                                             input logic [2:0] off);
        logic [63:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{56{s[7]}}, s[7:0]};
            3'b001:  load_ext = {{48{s[15]}}, s[15:0]};
            3'b010:  load_ext = {{32{s[31]}}, s[31:0]};
            3'b011:  load_ext = s;
            3'b100:  load_ext = {56'd0, s[7:0]};
            3'b101:  load_ext = {48'd0, s[15:0]};
            3'b110:  load_ext = {32'd0, s[31:0]};
            default: load_ext = 64'd0;
        endcase
    endfunction

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        we_r, we_s;
    logic [2:0]  f3_r, f3_s;
    logic [2:0]  off_r, off_s;
    logic        hs_s;
    logic [1:0]  chk_s;
    logic        timeout_s;

    logic        data_r_en_s, data_w_en_s, resp_valid_s;
    logic [7:0]  data_wmask_s;
    logic [63:0] data_addr_s, data_w_s, resp_rdata_s;
    logic [1:0]  resp_err_s;

    assign req_ready = (state_r == ST_IDLE);
    assign hs_s      = req_valid & req_ready;
    assign chk_s     = req_check(req_funct3, req_we, req_addr[2:0]);
    // An ack in the cycle that would reach MAX_WAIT wins over the timeout.
    assign timeout_s = !mem_ack && (({1'b0, cnt_r} + 9'd1) >= MAX_WAIT_W);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_nxt_s = (chk_s != ERR_OK) ? ST_RESP : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs, the captured request and the wait counter.
    always_comb begin
        data_r_en_s  = data_r_en;
        data_w_en_s  = data_w_en;
        data_wmask_s = data_wmask;
        data_addr_s  = data_addr;
        data_w_s     = data_w;
        resp_valid_s = resp_valid;
        resp_rdata_s = resp_rdata;
        resp_err_s   = resp_err;
        cnt_s        = cnt_r;
        we_s         = we_r;
        f3_s         = f3_r;
        off_s        = off_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    we_s  = req_we;
                    f3_s  = req_funct3;
                    off_s = req_addr[2:0];
                    cnt_s = 8'd0;
                    if (chk_s != ERR_OK) begin
                        resp_valid_s = 1'b1;
                        resp_err_s   = chk_s;
                        resp_rdata_s = 64'd0;
                    end else begin
                        data_r_en_s  = !req_we;
                        data_w_en_s  = req_we;
                        data_addr_s  = {req_addr[63:3], 3'b000};
                        data_wmask_s = base_mask(req_funct3[1:0]) << req_addr[2:0];
                        data_w_s     = req_wdata << {req_addr[2:0], 3'b000};
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    data_r_en_s  = 1'b0;
                    data_w_en_s  = 1'b0;
                    resp_valid_s = 1'b1;
                    resp_err_s   = ERR_OK;
                    resp_rdata_s = we_r ? 64'd0 : load_ext(data_r, f3_r, off_r);
                end else if (timeout_s) begin
                    data_r_en_s  = 1'b0;
                    data_w_en_s  = 1'b0;
                    resp_valid_s = 1'b1;
                    resp_err_s   = ERR_TIMEOUT;
                    resp_rdata_s = 64'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_s = 1'b0;
                    cnt_s        = 8'd0;
                end else begin
                    resp_valid_s = 1'b1;
                end
            end
            default: begin
                data_r_en_s  = 1'b0;
                data_w_en_s  = 1'b0;
                resp_valid_s = 1'b0;
                cnt_s        = 8'd0;
            end
        endcase
    end

    // Output, captured-request and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r_en  <= 1'b0;
            data_w_en  <= 1'b0;
            data_wmask <= 8'd0;
            data_addr  <= 64'd0;
            data_w     <= 64'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 2'b00;
            cnt_r      <= 8'd0;
            we_r       <= 1'b0;
            f3_r       <= 3'd0;
            off_r      <= 3'd0;
        end else begin
            data_r_en  <= data_r_en_s;
            data_w_en  <= data_w_en_s;
            data_wmask <= data_wmask_s;
            data_addr  <= data_addr_s;
            data_w     <= data_w_s;
            resp_valid <= resp_valid_s;
            resp_rdata <= resp_rdata_s;
            resp_err   <= resp_err_s;
            cnt_r      <= cnt_s;
            we_r       <= we_s;
            f3_r       <= f3_s;
            off_r      <= off_s;
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Randomized scoreboard bench for lsu_dmem_master.
// A memory model acknowledges each access after a chosen delay. A monitor compares
// every response with the result predicted from the RV64 load/store rules.
module tb_lsu_dmem_master;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        data_r_en, data_w_en;
    logic [7:0]  data_wmask;
    logic [63:0] data_addr, data_w;
    logic [63:0] data_r = 64'd0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    lsu_dmem_master #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .data_r_en(data_r_en), .data_w_en(data_w_en), .data_wmask(data_wmask),
        .data_addr(data_addr), .data_w(data_w), .data_r(data_r), .mem_ack(mem_ack)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accesses = 0;
    int exp_accesses = 0;

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  err;
        int          due;
        bit          bp;
    } exp_t;

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [63:0] wdata;
        int          size;
        logic [63:0] rdata;
        int          delay;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: error code, response data and response latency in cycles
    // after the handshake cycle.
    task automatic model(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input int delay,
                         output logic [1:0] err, output logic [63:0] res, output int lat);
        int size;
        int o;
        logic [63:0] val;
        logic [63:0] keep;
        size = 1 << f3[1:0];
        o    = int'(addr % 64'd8);
        res  = 64'd0;
        if (f3 == 3'd7)                  err = 2'd2;
        else if (addr % size != 64'd0)   err = 2'd1;
        else if (we && f3 >= 3'd4)       err = 2'd2;
        else                             err = 2'd0;
        if (err != 2'd0) begin
            lat = 1;
        end else if (delay >= MW) begin
            err = 2'd3;
            lat = 1 + MW;
        end else begin
            lat = delay + 2;
            if (!we) begin
                val = rdata >> (8 * o);
                if (size < 8) begin
                    keep = (64'd1 << (8 * size)) - 64'd1;
                    val  = val & keep;
                    if (f3 < 3'd4 && val[8 * size - 1]) val = val | ~keep;
                end
                res = val;
            end
        end
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input int delay, input bit bp);
        logic [1:0]  err;
        logic [63:0] res;
        int          lat;
        int          n;
        exp_t        e;
        mem_t        m;
        model(we, f3, addr, rdata, delay, err, res, lat);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = res; e.err = err; e.due = cyc + lat; e.bp = bp;
        exp_q.push_back(e);
        if (err == 2'd0 || err == 2'd3) begin
            m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata; m.delay = delay;
            m.size = 1 << f3[1:0];
            m.mask = 8'(((1 << m.size) - 1) << addr[2:0]);
            mem_q.push_back(m);
            exp_accesses++;
        end
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        req_funct3 = 3'($urandom_range(0, 7));
        req_we     = 1'($urandom_range(0, 1));
    endtask

    // Memory model: checks the lane placement while an enable is up and acks after the chosen delay.
    initial begin : memory
        mem_t cur;
        bit   active;
        int   en_cnt;
        int   o;
        active = 0;
        en_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active  = 0;
                en_cnt  = 0;
                mem_ack = 1'b0;
            end else if (data_r_en || data_w_en) begin
                if (!active) begin
                    active = 1;
                    en_cnt = 0;
                    accesses++;
                    if (mem_q.size() == 0) begin
                        chk("unexpected_enable", 64'd1, 64'd0);
                        cur.we = data_w_en; cur.addr = data_addr; cur.mask = data_wmask;
                        cur.wdata = 64'd0; cur.size = 0; cur.rdata = 64'd0; cur.delay = 1000;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end
                chk("data_r_en", 64'(data_r_en), 64'(!cur.we));
                chk("data_w_en", 64'(data_w_en), 64'(cur.we));
                chk("data_addr", data_addr, {cur.addr[63:3], 3'b000});
                if (cur.we) begin
                    chk("data_wmask", 64'(data_wmask), 64'(cur.mask));
                    o = int'(cur.addr[2:0]);
                    for (int i = 0; i < cur.size; i++)
                        chk("data_w_byte", 64'(data_w[8 * (o + i) +: 8]), 64'(cur.wdata[8 * i +: 8]));
                end
                mem_ack = (en_cnt == cur.delay);
                data_r  = mem_ack ? cur.rdata : {$urandom, $urandom};
                en_cnt++;
            end else begin
                if (active) begin
                    chk("enable_cycles", 64'(en_cnt), 64'((cur.delay < MW) ? cur.delay + 1 : MW));
                    active = 0;
                end
                mem_ack = ($urandom_range(0, 3) == 0);
                data_r  = {$urandom, $urandom};
            end
        end
    end

    // Response monitor: pops the scoreboard at each new response and drives resp_ready.
    initial begin : monitor
        exp_t        e;
        bit          holding;
        int          bp_left;
        logic [63:0] h_rdata;
        logic [1:0]  h_err;
        holding = 0;
        bp_left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding    = 0;
                resp_ready = 1'b0;
            end else if (resp_valid) begin
                chk("req_ready_busy", 64'(req_ready), 64'd0);
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", 64'd1, 64'd0);
                        bp_left = 0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", 64'(resp_err), 64'(e.err));
                        chk("resp_latency", 64'(cyc), 64'(e.due));
                        bp_left = e.bp ? 5 : 0;
                    end
                    h_rdata = resp_rdata;
                    h_err   = resp_err;
                    holding = 1;
                end else begin
                    chk("hold_rdata", resp_rdata, h_rdata);
                    chk("hold_err", 64'(resp_err), 64'(h_err));
                end
                if (bp_left > 0) begin
                    resp_ready = 1'b0;
                    bp_left--;
                end else begin
                    resp_ready = 1'($urandom_range(0, 2) != 0);
                end
                if (resp_ready) holding = 0;
            end else begin
                if (holding) begin
                    chk("resp_dropped", 64'(resp_valid), 64'd1);
                    holding = 0;
                end
                resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : stimulus
        bit          we;
        logic [2:0]  f3;
        logic [63:0] addr;
        repeat (3) @(negedge clk);
        chk("rst_data_r_en", 64'(data_r_en), 64'd0);
        chk("rst_data_w_en", 64'(data_w_en), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_data_addr", data_addr, 64'd0);
        chk("rst_data_w", data_w, 64'd0);
        chk("rst_wmask", 64'(data_wmask), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        // Directed cases.
        issue(1'b1, 3'b010, 64'h8000_0004, 64'h1122_3344_AABB_CCDD, 64'd0, 0, 1'b0);
        issue(1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 1'b0);
        issue(1'b0, 3'b100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1, 1'b0);
        issue(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 1'b0);
        issue(1'b0, 3'b011, 64'h8000_0010, 64'd0, 64'h1234, 50, 1'b0);
        issue(1'b0, 3'b011, 64'h8000_0018, 64'd0, 64'hDEAD_BEEF_0123_4567, 1, 1'b1);
        issue(1'b0, 3'b001, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, MW - 1, 1'b0);
        issue(1'b1, 3'b101, 64'h8000_0002, 64'h55, 64'd0, 0, 1'b0);
        issue(1'b1, 3'b110, 64'h8000_0001, 64'h55, 64'd0, 0, 1'b0);
        issue(1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 0, 1'b0);
        issue(1'b1, 3'b000, 64'h8000_0007, 64'h00AB, 64'd0, 2, 1'b0);
        issue(1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'hF000_0000_0000_0000, 0, 1'b0);

        // Random traffic, mostly aligned so that the memory is reached.
        for (int k = 0; k < 300; k++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
            issue(we, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 5), 1'($urandom_range(0, 9) == 0));
        end
        drain();

        // Asynchronous reset in the middle of a memory access.
        issue(1'b0, 3'b011, 64'h8000_0020, 64'd0, 64'h77, 50, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data_r_en", 64'(data_r_en), 64'd0);
        chk("arst_data_addr", data_addr, 64'd0);
        chk("arst_resp_valid", 64'(resp_valid), 64'd0);
        exp_q.delete();
        mem_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("arst_ready", 64'(req_ready), 64'd1);
        repeat (10) @(negedge clk);
        issue(1'b0, 3'b000, 64'h8000_0001, 64'd0, 64'h0000_0000_0000_7F00, 0, 1'b0);
        drain();
        chk("access_count", 64'(accesses), 64'(exp_accesses));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
